// File: rtl/collision_scheduler_pkg.sv
// Shared constants, types and bounce-resolution rule for the collision scheduler.
package collision_pkg;

  localparam int MAP_W    = 64;
  localparam int MAP_H    = 48;
  localparam int TILE_PX  = 10;
  localparam int MAP_BITS = MAP_W * MAP_H;
  localparam int ADDR_W   = 12;
  localparam int PX_W     = 21;

  localparam int CORNER_AL = 0;
  localparam int CORNER_AR = 1;
  localparam int CORNER_BL = 2;
  localparam int CORNER_BR = 3;

  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } dir_t;

  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } bnce_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK_AL,
    CHK_AR,
    CHK_BL,
    CHK_BR,
    RESOLVE,
    COMMIT
  } state_t;

  // Only the first solid corner in scan order decides; a non-matching dir yields no bounce.
  function automatic bnce_t resolve_bounce(logic [3:0] hits, dir_t dir);
    bnce_t b;
    b = '0;
    if (hits[CORNER_AL]) begin
      if (dir.l)      b.r = 1'b1;
      else if (dir.u) b.d = 1'b1;
    end else if (hits[CORNER_AR]) begin
      if (dir.r)      b.l = 1'b1;
      else if (dir.u) b.d = 1'b1;
    end else if (hits[CORNER_BL]) begin
      if (dir.l)      b.r = 1'b1;
      else if (dir.d) b.u = 1'b1;
    end else if (hits[CORNER_BR]) begin
      if (dir.r)      b.l = 1'b1;
      else if (dir.d) b.u = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/collision_scheduler_if.sv
// Sprite/map inputs and bounce results shared between the scheduler and its neighbours.
interface collision_scheduler_if #(
  parameter int NUM_SPR = 4
);
  import collision_pkg::*;

  logic                    frame_start;
  logic [MAP_BITS-1:0]     C_map;
  logic [NUM_SPR*20-1:0]   sprite_xpos;
  logic [NUM_SPR*20-1:0]   sprite_ypos;
  logic [NUM_SPR*10-1:0]   sprite_W;
  logic [NUM_SPR*10-1:0]   sprite_H;
  logic [NUM_SPR*4-1:0]    sprite_dir;
  logic [NUM_SPR*4-1:0]    bnce;
  logic [NUM_SPR-1:0]      coll;
  logic                    busy;
  logic                    done;

  modport slave (
    input  frame_start, C_map, sprite_xpos, sprite_ypos, sprite_W, sprite_H, sprite_dir,
    output bnce, coll, busy, done
  );

  modport master (
    output frame_start, C_map, sprite_xpos, sprite_ypos, sprite_W, sprite_H, sprite_dir,
    input  bnce, coll, busy, done
  );

endinterface

// File: rtl/tile_addr_calc.sv
// Pixel-to-tile conversion and map address; off-map tiles are flagged and never addressed.
module tile_addr_calc
  import collision_pkg::*;
(
  input  logic [PX_W-1:0]   px_x,
  input  logic [PX_W-1:0]   px_y,
  output logic [ADDR_W-1:0] addr,
  output logic              out_of_range
);

  logic [PX_W-1:0] tx;
  logic [PX_W-1:0] ty;

  always_comb begin
    tx           = px_x / PX_W'(TILE_PX);
    ty           = px_y / PX_W'(TILE_PX);
    out_of_range = (tx >= PX_W'(MAP_W)) || (ty >= PX_W'(MAP_H));
    addr         = '0;
    if (!out_of_range) addr = ADDR_W'(ty * PX_W'(MAP_W) + tx);
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame, time-shared corner lookup for all sprites with an atomic commit of bounce flags.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_SPR = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  collision_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx;
  logic [PX_W-1:0]       xl_px, xr_px, yt_px, yb_px;
  dir_t                  dir_q;
  logic [3:0]            hits;
  logic [NUM_SPR*4-1:0]  shadow;
  logic [NUM_SPR*4-1:0]  bnce_q;
  logic [NUM_SPR-1:0]    coll_q, coll_nx;
  logic                  done_q;

  logic                  busy_c, load_en, chk_en, resolve_en, commit_en;
  logic [1:0]            corner;
  logic [PX_W-1:0]       px_x, px_y;
  logic [ADDR_W-1:0]     addr;
  logic                  oor, hit, last_spr;

  assign last_spr = (idx == IDX_W'(NUM_SPR - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.frame_start) state_nx = LOAD;
      LOAD:    state_nx = CHK_AL;
      CHK_AL:  state_nx = CHK_AR;
      CHK_AR:  state_nx = CHK_BL;
      CHK_BL:  state_nx = CHK_BR;
      CHK_BR:  state_nx = RESOLVE;
      RESOLVE: state_nx = last_spr ? COMMIT : LOAD;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_c     = (state != IDLE);
    load_en    = (state == LOAD);
    resolve_en = (state == RESOLVE);
    commit_en  = (state == COMMIT);
    chk_en     = 1'b0;
    corner     = 2'(CORNER_AL);
    case (state)
      CHK_AL: begin chk_en = 1'b1; corner = 2'(CORNER_AL); end
      CHK_AR: begin chk_en = 1'b1; corner = 2'(CORNER_AR); end
      CHK_BL: begin chk_en = 1'b1; corner = 2'(CORNER_BL); end
      CHK_BR: begin chk_en = 1'b1; corner = 2'(CORNER_BR); end
      default: ;
    endcase
  end

  // Latch pixel edges once per sprite; the divider is shared across the four corner cycles.
  always_comb begin
    px_x = xl_px;
    px_y = yt_px;
    case (corner)
      2'(CORNER_AL): begin px_x = xl_px; px_y = yt_px; end
      2'(CORNER_AR): begin px_x = xr_px; px_y = yt_px; end
      2'(CORNER_BL): begin px_x = xl_px; px_y = yb_px; end
      default:       begin px_x = xr_px; px_y = yb_px; end
    endcase
  end

  tile_addr_calc u_tile_addr (
    .px_x         (px_x),
    .px_y         (px_y),
    .addr         (addr),
    .out_of_range (oor)
  );

  assign hit = oor | bus.C_map[addr];

  always_comb begin
    coll_nx = '0;
    for (int unsigned i = 0; i < NUM_SPR; i++) coll_nx[i] = |shadow[i*4 +: 4];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx    <= '0;
      xl_px  <= '0;
      xr_px  <= '0;
      yt_px  <= '0;
      yb_px  <= '0;
      dir_q  <= '0;
      hits   <= '0;
      shadow <= '0;
      bnce_q <= '0;
      coll_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && bus.frame_start) idx <= '0;
      if (load_en) begin
        xl_px <= PX_W'(bus.sprite_xpos[idx*20 +: 20]);
        yt_px <= PX_W'(bus.sprite_ypos[idx*20 +: 20]);
        xr_px <= PX_W'(bus.sprite_xpos[idx*20 +: 20]) + PX_W'(bus.sprite_W[idx*10 +: 10]);
        yb_px <= PX_W'(bus.sprite_ypos[idx*20 +: 20]) + PX_W'(bus.sprite_H[idx*10 +: 10]);
        dir_q <= dir_t'(bus.sprite_dir[idx*4 +: 4]);
      end
      if (chk_en) hits[corner] <= hit;
      if (resolve_en) begin
        shadow[idx*4 +: 4] <= resolve_bounce(hits, dir_q);
        idx                <= last_spr ? '0 : idx + IDX_W'(1);
      end
      if (commit_en) begin
        bnce_q <= shadow;
        coll_q <= coll_nx;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.bnce = bnce_q;
  assign bus.coll = coll_q;
  assign bus.busy = busy_c;
  assign bus.done = done_q;

endmodule
